iob_split_pipe: RTL and testbench

Parametrised successor to the native-bus splitter used for the instruction, data and peripheral buses. It decodes a select field in the master address and routes each request to one of N_SLAVES. Unlike the single-transaction splitter, it:
- tracks up to MAX_OUT outstanding requests;
- guarantees in-order responses;
- answers unmapped selects from an internal error responder;
- optionally registers the response path.

It drops into the system top wherever the existing splitters are used.

---
 rtl/iob_split_pkg.sv | 33 +++
 rtl/iob_split_if.sv | 38 +++
 rtl/iob_split_tracker.sv | 68 ++++++
 rtl/iob_split_pipe.sv | 106 ++++++++++
 tb/tb_iob_split_pipe.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_split_pkg.sv
// Shared widths, offsets and helpers for the pipelined native-bus splitter.
// Field offsets describe the packed m_req / m_resp bus layout.
package iob_split_pkg;

    localparam int REQ_VALID_W = 1;
    localparam int REQ_ADDR_W  = 32;
    localparam int REQ_WDATA_W = 32;
    localparam int REQ_WSTRB_W = REQ_WDATA_W / 8;

    localparam int REQ_WSTRB_O = 0;
    localparam int REQ_WDATA_O = REQ_WSTRB_O + REQ_WSTRB_W;
    localparam int REQ_ADDR_O  = REQ_WDATA_O + REQ_WDATA_W;
    localparam int REQ_VALID_O = REQ_ADDR_O + REQ_ADDR_W;
    localparam int REQ_W       = REQ_VALID_O + REQ_VALID_W;

    localparam int RESP_RDATA_W = 32;
    localparam int RESP_RDATA_O = 0;
    localparam int RESP_VALID_O = RESP_RDATA_O + RESP_RDATA_W;
    localparam int RESP_READY_O = RESP_VALID_O + 1;
    localparam int RESP_W       = RESP_READY_O + 1;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iob_split_if.sv
// Master-side request/response bus plus the broadcast slave-side bus.
// The splitter uses the slave modport; its environment uses master.
interface iob_split_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 4
);
    logic                       m_valid;
    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic [DATA_W/8-1:0]        m_wstrb;
    logic                       m_ack;
    logic                       m_rvalid;
    logic [DATA_W-1:0]          m_rdata;
    logic                       m_rerr;

    logic [N_SLAVES-1:0]        s_valid;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic [DATA_W/8-1:0]        s_wstrb;
    logic [N_SLAVES-1:0]        s_ack;
    logic [N_SLAVES-1:0]        s_rvalid;
    logic [N_SLAVES*DATA_W-1:0] s_rdata;

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        input  s_ack, s_rvalid, s_rdata,
        output m_ack, m_rvalid, m_rdata, m_rerr,
        output s_valid, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        output s_ack, s_rvalid, s_rdata,
        input  m_ack, m_rvalid, m_rdata, m_rerr,
        input  s_valid, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/iob_split_tracker.sv
// Outstanding-request tracker: count, current select, issue gating
// and the sticky stray-response flag.
module iob_split_tracker
    import iob_split_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_OUT  = 4,
    localparam int CNT_W   = clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_ack,
    input  logic                resp_v,
    input  logic [N_SLAVES-1:0] s_rvalid,
    output logic                allow,
    output logic                accept,
    output logic [CNT_W-1:0]    count,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                err_stray
);
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
    logic                err_stray_q, err_stray_d;
    logic [N_SLAVES-1:0] cur_mask;
    logic                idle;

    always_comb begin
        cur_mask = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            cur_mask[i] = (cur_sel_q == SEL_W'(i));
        end
        idle   = (count_q == '0);
        allow  = m_valid & (idle | ((sel == cur_sel_q) &
                 (count_q < CNT_W'(MAX_OUT))));
        accept = allow & sel_ack;

        count_d = count_q;
        if (accept & ~resp_v) begin
            count_d = count_q + CNT_W'(1);
        end else if (~accept & resp_v) begin
            count_d = count_q - CNT_W'(1);
        end

        cur_sel_d = accept ? sel : cur_sel_q;
        // off-select responses, or on-select with nothing in flight
        err_stray_d = err_stray_q | (|(s_rvalid & ~cur_mask)) |
                      (idle & (|(s_rvalid & cur_mask)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            cur_sel_q   <= '0;
            err_stray_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            cur_sel_q   <= cur_sel_d;
            err_stray_q <= err_stray_d;
        end
    end

    assign count     = count_q;
    assign cur_sel   = cur_sel_q;
    assign err_stray = err_stray_q;
endmodule

// File: rtl/iob_split_pipe.sv
// Pipelined in-order native-bus splitter with an internal error
// responder for unmapped selects and an optional response register.
module iob_split_pipe
    import iob_split_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_W    = 2,
    parameter int P_SLAVES = 31,
    parameter int MAX_OUT  = 4,
    parameter int REG_RESP = 0,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF),
    localparam int CNT_W   = clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    iob_split_if.slave       bus,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_stray
);
    typedef struct packed {
        logic              v;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel, cur_sel;
    logic [CNT_W-1:0]  count;
    logic              mapped, cur_mapped, sel_ack;
    logic              allow, accept, resp_v;
    logic              slv_rv;
    logic [DATA_W-1:0] slv_rd;
    logic              err_v_q, err_v_d;
    rsp_t              rsp_d, rsp_q;

    assign addr        = bus.m_addr;
    assign sel         = addr[P_SLAVES -: SEL_W];
    assign bus.s_addr  = addr;
    assign bus.s_wdata = bus.m_wdata;
    assign bus.s_wstrb = bus.m_wstrb;

    always_comb begin
        mapped     = {1'b0, sel} < (SEL_W + 1)'(N_SLAVES);
        cur_mapped = {1'b0, cur_sel} < (SEL_W + 1)'(N_SLAVES);
        sel_ack    = 1'b1;
        slv_rv     = 1'b0;
        slv_rd     = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel == SEL_W'(i)) sel_ack = bus.s_ack[i];
            if (cur_sel == SEL_W'(i)) begin
                slv_rv = bus.s_rvalid[i];
                slv_rd = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
        resp_v     = (cur_mapped ? slv_rv : err_v_q) & (count != '0);
        rsp_d.v    = resp_v;
        rsp_d.err  = resp_v & ~cur_mapped;
        rsp_d.data = resp_v ? (cur_mapped ? slv_rd : ERR_DATA) : '0;
    end

    always_comb begin
        bus.s_valid = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            bus.s_valid[i] = allow & (sel == SEL_W'(i));
        end
    end

    assign err_v_d = accept & ~mapped;

    iob_split_tracker #(
        .N_SLAVES (N_SLAVES),
        .SEL_W    (SEL_W),
        .MAX_OUT  (MAX_OUT)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .m_valid   (bus.m_valid),
        .sel       (sel),
        .sel_ack   (sel_ack),
        .resp_v    (resp_v),
        .s_rvalid  (bus.s_rvalid),
        .allow     (allow),
        .accept    (accept),
        .count     (count),
        .cur_sel   (cur_sel),
        .err_stray (err_stray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_v_q <= 1'b0;
            rsp_q   <= '0;
        end else begin
            err_v_q <= err_v_d;
            rsp_q   <= rsp_d;
        end
    end

    assign bus.m_ack    = accept;
    assign bus.m_rvalid = (REG_RESP != 0) ? rsp_q.v    : rsp_d.v;
    assign bus.m_rerr   = (REG_RESP != 0) ? rsp_q.err  : rsp_d.err;
    assign bus.m_rdata  = (REG_RESP != 0) ? rsp_q.data : rsp_d.data;
    assign outstanding  = count;
endmodule

// File: tb/tb_iob_split_pipe.sv
// Scoreboard bench: 4-slave combinational-response splitter plus a
// 3-slave registered-response splitter for the unmapped path.
module tb_iob_split_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iob_split_if #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(4)) ia ();
    iob_split_if #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3)) ib ();

    logic [2:0] out_a, out_b;
    logic       stray_a, stray_b;

    iob_split_pipe #(.N_SLAVES(4), .MAX_OUT(4), .REG_RESP(0)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave),
        .outstanding(out_a), .err_stray(stray_a)
    );

    iob_split_pipe #(.N_SLAVES(3), .MAX_OUT(4), .REG_RESP(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave),
        .outstanding(out_b), .err_stray(stray_b)
    );

    assign ia.s_ack = '1;
    assign ib.s_ack = '1;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [3:0] inj = '0;

    typedef struct {int due; logic [31:0] d;} sr_t;
    typedef struct {logic [31:0] d; logic e; int acc; int lat;} exp_t;
    sr_t  sq[4][$];
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        case (i)
            0: return 2;
            1: return 5;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] slv_data(input int i, input logic [31:0] a);
        return a ^ (32'h1111_1111 * 32'(i + 1));
    endfunction

    // slave models for dut_a: fixed latency, in order per slave
    initial begin
        sr_t t;
        logic rv;
        ia.s_rvalid = '0;
        ia.s_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 4; i++) begin
                rv = 1'b0;
                if (sq[i].size() > 0 && sq[i][0].due == cyc) begin
                    t = sq[i].pop_front();
                    ia.s_rdata[i*32 +: 32] = t.d;
                    rv = 1'b1;
                end
                ia.s_rvalid[i] = rv | inj[i];
            end
        end
    end

    // monitor: slave accepts, master accepts and responses
    initial begin
        logic [1:0] s;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                for (int i = 0; i < 4; i++) begin
                    if (ia.s_valid[i] & ia.s_ack[i])
                        sq[i].push_back(sr_t'{cyc + lat_of(i),
                                              slv_data(i, ia.s_addr)});
                end
                if (ia.m_valid & ia.m_ack) begin
                    s = ia.m_addr[31:30];
                    check("s_valid", ia.s_valid, 4'b0001 << s);
                    check("s_addr", ia.s_addr, ia.m_addr);
                    check("s_wdata", ia.s_wdata, ia.m_wdata);
                    check("s_wstrb", ia.s_wstrb, ia.m_wstrb);
                    sb.push_back(exp_t'{slv_data(int'(s), ia.m_addr), 1'b0,
                                        cyc, lat_of(int'(s))});
                end
                if (ia.m_rvalid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rvalid", ia.m_rvalid, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        check("rdata", ia.m_rdata, e.d);
                        check("rerr", ia.m_rerr, e.e);
                        check("latency", cyc - e.acc, e.lat);
                    end
                end
            end
        end
    end

    task automatic issue_a(input logic [31:0] addr, input logic [3:0] strb,
                           output int waited);
        ia.m_valid = 1'b1;
        ia.m_addr  = addr;
        ia.m_wdata = ~addr;
        ia.m_wstrb = strb;
        waited = 0;
        forever begin
            #4;
            if (ia.m_ack) break;
            check("held_s_valid", ia.s_valid, 4'b0000);
            if (waited == 40) begin
                check("ack_timeout", 1'b0, 1'b1);
                break;
            end
            waited++;
            @(negedge clk);
        end
        @(negedge clk);
        ia.m_valid = 1'b0;
    endtask

    task automatic drain_a(input string tag);
        for (int t = 0; t < 60; t++) begin
            if (out_a == 3'd0 && sb.size() == 0) break;
            @(negedge clk);
        end
        check({tag, "_out"}, out_a, 3'd0);
        check({tag, "_sb"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        ia.m_valid = 1'b0; ia.m_addr = '0; ia.m_wdata = '0; ia.m_wstrb = '0;
        ib.m_valid = 1'b0; ib.m_addr = '0; ib.m_wdata = '0; ib.m_wstrb = '0;
        ib.s_rvalid = '0; ib.s_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_out_a", out_a, 3'd0);
        check("rst_rvalid_a", ia.m_rvalid, 1'b0);
        check("rst_rdata_a", ia.m_rdata, 32'h0);
        check("rst_rerr_a", ia.m_rerr, 1'b0);
        check("rst_stray_a", stray_a, 1'b0);
        check("rst_rvalid_b", ib.m_rvalid, 1'b0);
        check("rst_out_b", out_b, 3'd0);
        rst = 1'b0;
        @(negedge clk);

        // unmapped select on the registered-response instance
        ib.m_valid = 1'b1;
        ib.m_addr  = 32'hC000_0004;
        #4 check("b_unmap_ack", ib.m_ack, 1'b1);
        check("b_unmap_sval", ib.s_valid, 3'b000);
        @(negedge clk);
        ib.m_valid = 1'b0;
        #4 check("b_unmap_c1", ib.m_rvalid, 1'b0);
        @(negedge clk);
        #4 check("b_unmap_rv", ib.m_rvalid, 1'b1);
        check("b_unmap_rdata", ib.m_rdata, 32'hDEADBEEF);
        check("b_unmap_rerr", ib.m_rerr, 1'b1);
        check("b_unmap_out", out_b, 3'd0);
        @(negedge clk);
        #4 check("b_unmap_c3", ib.m_rvalid, 1'b0);

        // two back-to-back unmapped requests
        @(negedge clk);
        ib.m_valid = 1'b1;
        ib.m_addr  = 32'hC000_0008;
        #4 check("b_b2b_ack0", ib.m_ack, 1'b1);
        @(negedge clk);
        #4 check("b_b2b_ack1", ib.m_ack, 1'b1);
        @(negedge clk);
        ib.m_valid = 1'b0;
        #4 check("b_b2b_rv0", ib.m_rvalid, 1'b1);
        @(negedge clk);
        #4 check("b_b2b_rv1", ib.m_rvalid, 1'b1);
        check("b_b2b_rerr", ib.m_rerr, 1'b1);
        @(negedge clk);
        #4 check("b_b2b_end", ib.m_rvalid, 1'b0);

        // mapped read through the registered response path
        @(negedge clk);
        ib.m_valid = 1'b1;
        ib.m_addr  = 32'h4000_0000;
        #4 check("b_map_ack", ib.m_ack, 1'b1);
        check("b_map_sval", ib.s_valid, 3'b010);
        @(negedge clk);
        ib.m_valid = 1'b0;
        ib.s_rvalid[1] = 1'b1;
        ib.s_rdata[63:32] = 32'h1234_5678;
        #4 check("b_map_c1", ib.m_rvalid, 1'b0);
        @(negedge clk);
        ib.s_rvalid = '0;
        #4 check("b_map_rv", ib.m_rvalid, 1'b1);
        check("b_map_rdata", ib.m_rdata, 32'h1234_5678);
        check("b_map_rerr", ib.m_rerr, 1'b0);
        @(negedge clk);

        // single read and a write to slave 2
        issue_a(32'h8000_0010, 4'h0, w);
        check("single_wait", w, 0);
        check("single_out", out_a, 3'd1);
        drain_a("single");
        issue_a(32'h8000_0020, 4'hF, w);
        drain_a("write");

        // pipelined burst to slave 1, fifth held until first response
        for (int k = 0; k < 4; k++) begin
            issue_a(32'h4000_0000 + 32'(k * 4), 4'h0, w);
            check("burst_wait", w, 0);
        end
        check("burst_full", out_a, 3'd4);
        issue_a(32'h4000_0040, 4'h0, w);
        check("burst5_wait", w, 2);
        drain_a("burst");

        // select switch stalls until the old slave drains
        issue_a(32'h0000_0100, 4'h0, w);
        issue_a(32'hC000_0100, 4'h0, w);
        check("switch_wait", w, 2);
        drain_a("switch");

        // accept and response in the same cycle
        issue_a(32'hC000_0000, 4'h0, w);
        issue_a(32'hC000_0004, 4'h3, w);
        check("simul_wait", w, 0);
        check("simul_out", out_a, 3'd1);
        drain_a("simul");

        // stray response on a non-current slave
        issue_a(32'h0000_0000, 4'h0, w);
        drain_a("pre_stray");
        check("stray_pre", stray_a, 1'b0);
        inj = 4'b0010;
        #4 check("stray_nofwd", ia.m_rvalid, 1'b0);
        @(negedge clk);
        inj = 4'b0000;
        #4 check("stray_set", stray_a, 1'b1);
        @(negedge clk);

        // reset with three requests in flight
        for (int k = 0; k < 3; k++) issue_a(32'h4000_0100 + 32'(k * 4), 4'h0, w);
        check("rst_pre_out", out_a, 3'd3);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #4 check("rst_mid_out", out_a, 3'd0);
        check("rst_mid_rvalid", ia.m_rvalid, 1'b0);
        check("rst_mid_stray", stray_a, 1'b0);
        repeat (6) @(negedge clk);
        check("rst_late_stray", stray_a, 1'b1);
        check("rst_late_out", out_a, 3'd0);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
